// File: rtl/twin_pair_serializer.sv
// rtl/twin_pair_serializer.sv - serializes one (a, b) word pair MSB first onto a single handshaked bit line
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     a/b hold a pair to transfer
//   in_ready     pair can be accepted (IDLE only)
//   a, b         first and second word of the pair
//   ser_ready    sink takes the presented bit this cycle
//   ser_valid    ser_out carries a frame bit
//   ser_out      serial data, all of a then all of b, MSB first
//   frame_start  high while the first bit of the frame is presented
//   done         one-cycle pulse after the last bit of b is taken
module twin_pair_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_A = 2'd1,
    SHIFT_B = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic            load;
  logic [CW-1:0]   idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        a_reg <= a;
        b_reg <= b;
      end
    end
  end

  // Next state: counter advances only when the presented bit is taken,
  // so a stalled sink leaves state, count and the output bit untouched.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT_A;
          cnt_nxt   = '0;
        end
      end
      SHIFT_A: begin
        if (ser_ready) begin
          if (cnt == LAST) begin
            state_nxt = SHIFT_B;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      SHIFT_B: begin
        if (ser_ready) begin
          if (cnt == LAST) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore outputs: decoded from registered state and count only.
  always_comb begin
    idx         = LAST - cnt;
    in_ready    = (state == IDLE);
    ser_valid   = (state == SHIFT_A) || (state == SHIFT_B);
    frame_start = (state == SHIFT_A) && (cnt == '0);
    done        = (state == DONE);
    ser_out     = 1'b0;
    if (state == SHIFT_A) begin
      ser_out = a_reg[idx];
    end else if (state == SHIFT_B) begin
      ser_out = b_reg[idx];
    end
  end

endmodule

// File: tb/tb_twin_pair_serializer.sv
// tb/tb_twin_pair_serializer.sv - scoreboard bench for twin_pair_serializer
module tb_twin_pair_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ser_ready;
  logic             ser_valid;
  logic             ser_out;
  logic             frame_start;
  logic             done;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  bit exp_bits[$];
  bit exp_fs[$];
  int exp_done[$];

  twin_pair_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .ser_ready(ser_ready),
    .ser_valid(ser_valid),
    .ser_out(ser_out),
    .frame_start(frame_start),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Expected frame bits, in order; nbits < 2*WIDTH models a frame cut by reset.
  task automatic push_frame(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input int nbits, input int done_edge);
    logic [2*WIDTH-1:0] frame;
    frame = {av, bv};
    for (int i = 0; i < nbits; i++) begin
      exp_bits.push_back(frame[2*WIDTH-1-i]);
      exp_fs.push_back(i == 0);
    end
    if (done_edge >= 0) exp_done.push_back(done_edge);
  endtask

  // Presents a pair from a falling edge; returns the edge number that accepts it.
  task automatic start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, output int e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_timeout", int'(n < 100), 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    e = ecnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_bits.size() == 0 && exp_done.size() == 0 && in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("quiet_timeout", int'(n < 300), 1);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a bit counts as taken when ser_valid && ser_ready ahead of an edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ser_valid && ser_ready) begin
        if (exp_bits.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          check("ser_out", int'(ser_out), int'(exp_bits.pop_front()));
          check("frame_start", int'(frame_start), int'(exp_fs.pop_front()));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else check("done_edge", ecnt, exp_done.pop_front());
      end
    end
  end

  initial begin
    int e1;
    int e2;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    ser_ready = 1'b1;

    // Reset state
    step(2);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_ser_valid", int'(ser_valid), 0);
    check("rst_ser_out", int'(ser_out), 0);
    check("rst_done", int'(done), 0);
    check("rst_frame_start", int'(frame_start), 0);
    rst = 1'b0;

    // Plain frame 0x43/0x63, sink always ready
    start(8'd67, 8'd99, e1);
    push_frame(8'd67, 8'd99, 16, e1 + 16);
    in_valid = 1'b0;
    check("busy_in_ready", int'(in_ready), 0);
    wait_quiet();

    // Sink stalls three cycles on bit 5
    start(8'd67, 8'd99, e1);
    push_frame(8'd67, 8'd99, 16, e1 + 19);
    in_valid = 1'b0;
    step(5);
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", int'(ser_out), 0);
      check("stall_valid", int'(ser_valid), 1);
      step(1);
    end
    check("stall_hold", int'(ser_out), 0);
    ser_ready = 1'b1;
    wait_quiet();

    // in_valid held: second pair taken the cycle after done
    @(negedge clk);
    a = 8'd67;
    b = 8'd99;
    in_valid = 1'b1;
    e1 = ecnt + 1;
    e2 = e1 + 18;
    push_frame(8'd67, 8'd99, 16, e1 + 16);
    push_frame(8'd43, 8'd32, 16, e2 + 16);
    step(1);
    a = 8'd43;
    b = 8'd32;
    n = 0;
    while (ecnt < e2 && n < 100) begin
      step(1);
      n++;
    end
    check("hold_valid_timeout", int'(n < 100), 1);
    in_valid = 1'b0;
    wait_quiet();

    // New request during SHIFT_A must be ignored
    start(8'd67, 8'd99, e1);
    push_frame(8'd67, 8'd99, 16, e1 + 16);
    in_valid = 1'b0;
    step(3);
    a = 8'd255;
    in_valid = 1'b1;
    check("busy_ignore_ready", int'(in_ready), 0);
    step(5);
    check("busy_ignore_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_quiet();

    // Reset at bit 10 discards the frame, no done pulse
    start(8'd67, 8'd99, e1);
    push_frame(8'd67, 8'd99, 10, -1);
    in_valid = 1'b0;
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_ser_valid", int'(ser_valid), 0);
    check("midrst_done", int'(done), 0);
    step(25);

    check("leftover_bits", exp_bits.size(), 0);
    check("leftover_done", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
